// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and constants for the scoreboarded register file
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_IDX = 0;
  localparam int MAX_RD = 4;
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode-stage read, writeback and issue signals of the register file
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] Read_register;
  logic [NUM_RD*DATA_W-1:0] Read_data;
  logic [NUM_RD-1:0] Read_pending;
  logic Hazard;
  logic [ADDR_W-1:0] Write_register;
  logic [DATA_W-1:0] Write_data;
  logic RegWrite;
  logic Issue_valid;
  logic [ADDR_W-1:0] Issue_register;
  logic [ADDR_W:0] Pending_count;
  modport master (
    output Read_register, Write_register, Write_data, RegWrite, Issue_valid, Issue_register,
    input Read_data, Read_pending, Hazard, Pending_count
  );
  modport slave (
    input Read_register, Write_register, Write_data, RegWrite, Issue_valid, Issue_register,
    output Read_data, Read_pending, Hazard, Pending_count
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits, pending count and read hazard flags
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int ZERO_REG = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue_valid,
  input  logic [ADDR_W-1:0] issue_register,
  input  logic reg_write,
  input  logic [ADDR_W-1:0] write_register,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0] rd_bypass,
  output logic [NUM_RD-1:0] rd_pending,
  output logic hazard,
  output logic [ADDR_W:0] pending_count
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DEPTH-1:0] pending, pending_nxt;
  logic [ADDR_W:0] count_nxt;
  logic set_v, inc, dec;
  always_comb begin
    set_v = issue_valid && !(ZERO_REG != 0 && issue_register == ADDR_W'(ZERO_IDX));
    inc = set_v && !pending[issue_register];
    dec = reg_write && pending[write_register] && !(set_v && issue_register == write_register);
    pending_nxt = pending;
    if (reg_write) pending_nxt[write_register] = 1'b0;
    // a new producer supersedes the one being written back
    if (set_v) pending_nxt[issue_register] = 1'b1;
    count_nxt = pending_count + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending <= '0;
      pending_count <= '0;
    end else begin
      pending <= pending_nxt;
      pending_count <= count_nxt;
    end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rp
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[i*ADDR_W +: ADDR_W];
    assign rd_pending[i] = pending[a] && !rd_bypass[i] && !(ZERO_REG != 0 && a == ADDR_W'(ZERO_IDX));
  end
  assign hazard = |rd_pending;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised multi-port register file with zero register, write bypass
// and a pending-write scoreboard for decode-stage hazard detection
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input logic clk,
  input logic rst_n,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [NUM_RD-1:0] byp;
  logic we;
  assign we = bus.RegWrite && !(ZERO_REG != 0 && bus.Write_register == ADDR_W'(ZERO_IDX));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (we) begin
      mem[bus.Write_register] <= bus.Write_data;
    end
  for (genvar i = 0; i < MAX_RD; i++) begin : g_rd
    if (i < NUM_RD) begin : g_port
      logic [ADDR_W-1:0] a;
      logic z;
      assign a = bus.Read_register[i*ADDR_W +: ADDR_W];
      assign z = ZERO_REG != 0 && a == ADDR_W'(ZERO_IDX);
      // forwarding is held off during reset so reads stay at the cleared value
      assign byp[i] = BYPASS != 0 && rst_n && bus.RegWrite && bus.Write_register == a;
      assign bus.Read_data[i*DATA_W +: DATA_W] = z ? '0 : byp[i] ? bus.Write_data : mem[a];
    end
  end
  regfile_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk),
    .rst_n(rst_n),
    .issue_valid(bus.Issue_valid),
    .issue_register(bus.Issue_register),
    .reg_write(bus.RegWrite),
    .write_register(bus.Write_register),
    .rd_addr(bus.Read_register),
    .rd_bypass(byp),
    .rd_pending(bus.Read_pending),
    .hazard(bus.Hazard),
    .pending_count(bus.Pending_count)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven, hand-sequenced and randomized model checks of regfile_sb
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) if0 ();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) if1 ();
  regfile_sb_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) if2 ();

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  regfile_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  typedef struct {
    logic [4:0] ra0, ra1;
    logic we;
    logic [4:0] wa;
    logic [31:0] wd;
    logic iv;
    logic [4:0] ia;
    logic [31:0] d0, d1;
    logic [1:0] p;
    logic [5:0] cnt;
  } vec_t;
  vec_t vecs[17];

  logic [31:0] m_mem [32];
  logic m_pend [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic [4:0] ra0, ra1, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic iv, input logic [4:0] ia);
    if0.Read_register = {ra1, ra0};
    if0.RegWrite = we;
    if0.Write_register = wa;
    if0.Write_data = wd;
    if0.Issue_valid = iv;
    if0.Issue_register = ia;
  endtask

  task automatic drive1(input logic [4:0] ra0, ra1, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic iv, input logic [4:0] ia);
    if1.Read_register = {ra1, ra0};
    if1.RegWrite = we;
    if1.Write_register = wa;
    if1.Write_data = wd;
    if1.Issue_valid = iv;
    if1.Issue_register = ia;
  endtask

  task automatic drive2(input logic [11:0] ra, input logic we, input logic [2:0] wa,
                        input logic [15:0] wd, input logic iv, input logic [2:0] ia);
    if2.Read_register = ra;
    if2.RegWrite = we;
    if2.Write_register = wa;
    if2.Write_data = wd;
    if2.Issue_valid = iv;
    if2.Issue_register = ia;
  endtask

  function automatic vec_t mk(input logic [4:0] ra0, ra1, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic iv, input logic [4:0] ia,
                              input logic [31:0] d0, d1, input logic [1:0] p, input logic [5:0] cnt);
    vec_t v;
    v.ra0 = ra0; v.ra1 = ra1; v.we = we; v.wa = wa; v.wd = wd; v.iv = iv; v.ia = ia;
    v.d0 = d0; v.d1 = d1; v.p = p; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(1, 2, 0, 0, 0,            0, 0, 0,            0,            2'b00, 0);
    vecs[1]  = mk(1, 1, 1, 1, 32'h00FFFAFF, 0, 0, 32'h00FFFAFF, 32'h00FFFAFF, 2'b00, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0,            0, 0, 32'h00FFFAFF, 0,            2'b00, 0);
    vecs[3]  = mk(0, 0, 1, 0, 32'hABCDEF,   1, 0, 0,            0,            2'b00, 0);
    vecs[4]  = mk(0, 1, 0, 0, 0,            0, 0, 0,            32'h00FFFAFF, 2'b00, 0);
    vecs[5]  = mk(3, 4, 0, 0, 0,            1, 3, 0,            0,            2'b00, 0);
    vecs[6]  = mk(3, 4, 0, 0, 0,            1, 4, 0,            0,            2'b01, 1);
    vecs[7]  = mk(3, 4, 0, 0, 0,            0, 0, 0,            0,            2'b11, 2);
    vecs[8]  = mk(3, 4, 1, 3, 32'h0FAFAFAF, 0, 0, 32'h0FAFAFAF, 0,            2'b10, 2);
    vecs[9]  = mk(3, 4, 0, 0, 0,            0, 0, 32'h0FAFAFAF, 0,            2'b10, 1);
    vecs[10] = mk(5, 4, 0, 0, 0,            1, 5, 0,            0,            2'b10, 1);
    vecs[11] = mk(5, 5, 1, 5, 32'hADDFA,    1, 5, 32'hADDFA,    32'hADDFA,    2'b00, 2);
    vecs[12] = mk(5, 5, 0, 0, 0,            0, 0, 32'hADDFA,    32'hADDFA,    2'b11, 2);
    vecs[13] = mk(5, 3, 0, 0, 0,            1, 5, 32'hADDFA,    32'h0FAFAFAF, 2'b01, 2);
    vecs[14] = mk(5, 4, 0, 0, 0,            0, 0, 32'hADDFA,    0,            2'b11, 2);
    vecs[15] = mk(6, 6, 1, 6, 32'h12345678, 0, 0, 32'h12345678, 32'h12345678, 2'b00, 2);
    vecs[16] = mk(6, 4, 0, 0, 0,            0, 0, 32'h12345678, 0,            2'b10, 2);

    rst_n = 1'b0;
    drive0(0, 0, 0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0, 0, 0);
    drive2(0, 0, 0, 0, 0, 0);
    repeat (2) tick();

    drive0(1, 2, 1, 1, 32'hDEADBEEF, 1, 3);
    #3;
    chk("rst_bypass_gated_d0", if0.Read_data[31:0], 0);
    chk("rst_d1", if0.Read_data[63:32], 0);
    chk("rst_pending", if0.Read_pending, 0);
    tick();
    drive0(1, 2, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #3;
    chk("rst_release_d0", if0.Read_data[31:0], 0);
    chk("rst_release_count", if0.Pending_count, 0);
    chk("rst_release_hazard", if0.Hazard, 0);

    tick();
    drive0(1, 1, 1, 1, 32'hFFFAFF, 0, 0);
    #1;
    rst_n = 1'b0;
    #2;
    chk("midrst_bypass_gated", if0.Read_data[31:0], 0);
    tick();
    drive0(1, 1, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #3;
    chk("midrst_r1_discarded", if0.Read_data[31:0], 0);

    for (int i = 0; i < 17; i++) begin
      tick();
      drive0(vecs[i].ra0, vecs[i].ra1, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].iv, vecs[i].ia);
      #3;
      chk($sformatf("vec%0d_d0", i), if0.Read_data[31:0], vecs[i].d0);
      chk($sformatf("vec%0d_d1", i), if0.Read_data[63:32], vecs[i].d1);
      chk($sformatf("vec%0d_pend", i), if0.Read_pending, vecs[i].p);
      chk($sformatf("vec%0d_hazard", i), if0.Hazard, |vecs[i].p);
      chk($sformatf("vec%0d_count", i), if0.Pending_count, vecs[i].cnt);
    end

    tick();
    drive0(0, 0, 0, 0, 0, 0, 0);
    drive1(1, 1, 1, 1, 32'h00FFFAFF, 0, 0);
    #3;
    chk("nobyp_old_value", if1.Read_data, 0);
    tick();
    drive1(1, 2, 0, 0, 0, 1, 2);
    #3;
    chk("nobyp_after_edge", if1.Read_data[31:0], 32'h00FFFAFF);
    chk("nobyp_pend_before", if1.Read_pending, 0);
    tick();
    drive1(2, 1, 1, 2, 32'h55, 0, 0);
    #3;
    chk("nobyp_write_not_fwd", if1.Read_data[31:0], 0);
    chk("nobyp_pend_kept", if1.Read_pending, 2'b01);
    chk("nobyp_hazard", if1.Hazard, 1);
    chk("nobyp_count1", if1.Pending_count, 1);
    tick();
    drive1(2, 1, 0, 0, 0, 0, 0);
    #3;
    chk("nobyp_written", if1.Read_data[31:0], 32'h55);
    chk("nobyp_cleared", if1.Read_pending, 0);
    chk("nobyp_count0", if1.Pending_count, 0);

    tick();
    drive1(0, 0, 0, 0, 0, 0, 0);
    drive2({3'd6, 3'd6, 3'd6, 3'd6}, 1, 6, 16'h1234, 0, 0);
    #3;
    chk("w4_bypass_r6", if2.Read_data, {4{16'h1234}});
    tick();
    drive2({3'd7, 3'd7, 3'd7, 3'd7}, 1, 7, 16'hABDA, 0, 0);
    #3;
    chk("w4_bypass_r7", if2.Read_data, {4{16'hABDA}});
    tick();
    drive2({3'd6, 3'd7, 3'd6, 3'd7}, 0, 0, 0, 0, 0);
    #3;
    chk("w4_mixed_ports", if2.Read_data, {16'h1234, 16'hABDA, 16'h1234, 16'hABDA});
    for (int r = 1; r <= 7; r++) begin
      tick();
      drive2({4{3'(r)}}, 0, 0, 0, 1, 3'(r));
      #3;
      chk($sformatf("w4_count_before_issue%0d", r), if2.Pending_count, r - 1);
    end
    tick();
    drive2({3'd7, 3'd1, 3'd3, 3'd0}, 0, 0, 0, 1, 0);
    #3;
    chk("w4_count_full", if2.Pending_count, 7);
    chk("w4_pend_ports", if2.Read_pending, 4'b1110);
    chk("w4_hazard", if2.Hazard, 1);
    tick();
    drive2({4{3'd7}}, 0, 0, 0, 1, 7);
    #3;
    chk("w4_no_wrap", if2.Pending_count, 7);
    tick();
    drive2({4{3'd7}}, 1, 7, 16'h0, 0, 0);
    #3;
    chk("w4_waw_count", if2.Pending_count, 7);
    chk("w4_bypass_clears_pend", if2.Read_pending, 0);
    tick();
    drive2({4{3'd7}}, 0, 0, 0, 0, 0);
    #3;
    chk("w4_count_after_wb", if2.Pending_count, 6);

    tick();
    drive2(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    for (int k = 0; k < 32; k++) begin
      m_mem[k] = '0;
      m_pend[k] = 1'b0;
    end
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [4:0] ra[2];
      logic [4:0] wa, ia;
      logic [31:0] wd, ed;
      logic we, iv, ep;
      int pc;
      tick();
      for (int j = 0; j < 2; j++) ra[j] = 5'($urandom_range(0, n[0] ? 31 : 7));
      wa = 5'($urandom_range(0, 7));
      ia = 5'($urandom_range(0, n[1] ? 31 : 7));
      wd = $urandom;
      we = ($urandom_range(0, 2) == 0);
      iv = ($urandom_range(0, 2) == 0);
      drive0(ra[0], ra[1], we, wa, wd, iv, ia);
      #3;
      pc = 0;
      for (int k = 0; k < 32; k++) pc += int'(m_pend[k]);
      for (int j = 0; j < 2; j++) begin
        ed = (ra[j] == 0) ? 32'h0 : (we && wa == ra[j]) ? wd : m_mem[ra[j]];
        ep = (ra[j] != 0) && !(we && wa == ra[j]) && m_pend[ra[j]];
        chk($sformatf("rnd%0d_d%0d", n, j), if0.Read_data[j*32 +: 32], ed);
        chk($sformatf("rnd%0d_p%0d", n, j), if0.Read_pending[j], ep);
      end
      chk($sformatf("rnd%0d_count", n), if0.Pending_count, pc);
      if (we && wa != 0) m_mem[wa] = wd;
      if (we) m_pend[wa] = 1'b0;
      if (iv && ia != 0) m_pend[ia] = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 2-read/1-write MIPS register file.
- Generalised in data width, depth and read-port count.
- Adds a hardwired-zero register, optional write-to-read bypass, and a per-register scoreboard of pending writes with hazard flags.
- Sits in the decode stage: operands are read here, and issue/writeback traffic updates the scoreboard.

Parameters:
- DATA_W, 32, data width in bits.
- ADDR_W, 5, register address width; depth is 2**ADDR_W.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes and issues.
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching reads and clears their hazard.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Read_register  in  NUM_RD*ADDR_W  read addresses; port i is bits [i*ADDR_W +: ADDR_W].
- Read_data  out  NUM_RD*DATA_W  read data; port i is bits [i*DATA_W +: DATA_W].
- Read_pending  out  NUM_RD  per-port flag: the addressed register awaits a write.
- Hazard  out  1  OR of Read_pending.
- Write_register  in  ADDR_W  write address.
- Write_data  in  DATA_W  write data.
- RegWrite  in  1  write enable (writeback).
- Issue_valid  in  1  an instruction producing Issue_register is issued this cycle.
- Issue_register  in  ADDR_W  destination of the issued instruction.
- Pending_count  out  ADDR_W+1  number of registers currently pending.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All storage cleared to 0.
  - All pending bits and Pending_count cleared to 0.
  - Bypass gated off while rst_n is low, so Read_data reads 0 and Read_pending reads 0.
- Write:
  - On rising clk, when RegWrite is high and not (ZERO_REG and Write_register==0), mem[Write_register] <= Write_data.
  - Latency: 1 edge.
- Read: combinational, zero latency, ports fully independent, and any port may address any register.
  - Priority per port i, first match wins:
    1. ZERO_REG and address 0 -> 0.
    2. BYPASS, rst_n high, RegWrite high and Write_register == address -> Write_data.
    3. Otherwise mem[address].
  - With BYPASS=0, a same-cycle write is visible only after the edge.
- Scoreboard: one pending bit per register, updated on rising clk.
  - Set: Issue_valid high, and Issue_register is not the zero register when ZERO_REG=1.
  - Clear: RegWrite high on Write_register.
  - Set and clear on the same register in the same cycle: set wins, because a new producer supersedes the old one.
  - Issue to an already-pending register (WAW): the bit stays set.
  - RegWrite to a non-pending register: a legal plain write; the bit stays 0.
- Read_pending[i]:
  - Equals pending[Read_register_i].
  - Forced 0 for the zero register when ZERO_REG=1.
  - Forced 0 when BYPASS=1 and the same-cycle write matches the address.
- Pending_count: registered; next = count + (set of a non-pending register) - (clear of a pending register, not overridden by set).
  - Never wraps, since maximum equals depth.
  - Must always equal the popcount of the pending bits.
- Reset mid-operation: state is discarded immediately, with no completion of in-flight updates.
- Out-of-range behaviour: none exists; every address is valid.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_W/ADDR_W defaults.
  - The zero-register index constant.
  - The NUM_RD upper bound.
- One natural sub-module, regfile_scoreboard: pending bits, Pending_count and Read_pending generation.
- Storage, write logic and read muxing/bypass stay in the top module, with read ports built by a generate loop.

Test Plan:
- Reset, then read ports 0/1 at registers 1 and 2 -> Read_data 0, Read_pending 0, Pending_count 0. Then pulse rst_n low mid-write of 0xFFFAFF to r1 -> r1 still reads 0 after release.
- Write 0x00FFFAFF to r1 while reading r1 on both ports, BYPASS=1 -> Read_data shows 0x00FFFAFF in the same cycle. Rerun with BYPASS=0 -> old value 0 before the edge, 0x00FFFAFF after.
- Write 0xABCDEF to r0, ZERO_REG=1; issue r0 -> r0 reads 0, Read_pending 0, Pending_count unchanged.
- Issue r3, r4 on successive cycles -> Pending_count 1 then 2. Read r3 -> Read_pending[0]=1, Hazard=1. Write 0x0FAFAFAF to r3 -> same-cycle Read_pending[0]=0 (bypass), count 1 after the edge.
- Same cycle: Issue r5 and RegWrite r5=0xADDFA with r5 already pending -> pending bit stays 1, count unchanged, r5 reads 0xADDFA. Then issue r5 again (WAW) -> count unchanged.
- NUM_RD=4, ADDR_W=3, DATA_W=16: write 0xABDA to r7, read r7 on all 4 ports plus r6 -> all four return 0xABDA, independent and correct. Issue all of r1..r7 -> Pending_count 7, no wrap.
